// File: rtl/gbuff_arbiter.sv
// Arbiter for the single-port global buffer.
// Round-robin grant among NREQ requesters, with optional locked bursts of up
// to MAX_BURST transfers. Drives the buffer port combinationally in the grant
// cycle and returns read data one cycle later.
//
// Handshake: requester k presents req[k] with we/lock/addr/wdata and holds
// them until gnt[k]; a transfer happens at the rising edge where req[k] and
// gnt[k] are both high. A granted read yields rvalid[k] for exactly the next
// cycle, with rdata taken straight from the buffer's registered output.
module gbuff_arbiter #(
   parameter int NREQ      = 3,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ-1:0]        lock,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   gb_wr_en,
   output logic [ADDR_W-1:0]      gb_index,
   output logic [DATA_W-1:0]      gb_data_in,
   input  logic [DATA_W-1:0]      gb_data_out,
   output logic                   dbg_locked
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state, state_n;
   logic [PTR_W-1:0]   ptr, ptr_n;
   logic [PTR_W-1:0]   owner, owner_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [NREQ-1:0]    gnt_c;
   logic [PTR_W-1:0]   g_idx;
   logic               xfer;
   logic               sel_we;
   logic               sel_lock;
   logic               found;
   int                 cand;

   // Index after k, wrapping at NREQ.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] k);
      if (int'(k) >= NREQ - 1) return '0;
      else return k + 1'b1;
   endfunction

   // Grant selection and buffer port mux; everything held at zero in reset.
   always_comb begin
      gnt_c      = '0;
      g_idx      = '0;
      found      = 1'b0;
      cand       = 0;
      gb_index   = '0;
      gb_data_in = '0;
      if (!rst) begin
         if (state == LOCKED) begin
            for (int k = 0; k < NREQ; k++)
               if (owner == PTR_W'(k)) gnt_c[k] = req[k];
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               cand = (int'(ptr) + i) % NREQ;
               for (int k = 0; k < NREQ; k++)
                  if (!found && cand == k && req[k]) begin
                     gnt_c[k] = 1'b1;
                     found    = 1'b1;
                  end
            end
         end
         for (int k = 0; k < NREQ; k++)
            if (gnt_c[k]) begin
               g_idx      = PTR_W'(k);
               gb_index   = addr[k*ADDR_W +: ADDR_W];
               gb_data_in = wdata[k*DATA_W +: DATA_W];
            end
      end
   end

   assign xfer       = |gnt_c;
   assign sel_we     = |(gnt_c & we);
   assign sel_lock   = |(gnt_c & lock);
   assign gnt        = gnt_c;
   assign gb_wr_en   = sel_we;
   assign rdata      = gb_data_out;
   assign dbg_locked = (state == LOCKED);

   // Next-state logic: round-robin pointer advance and burst tracking.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (xfer) begin
               if (sel_lock && MAX_BURST > 1) begin
                  state_n = LOCKED;
                  owner_n = g_idx;
                  cnt_n   = CNT_W'(1);
               end else begin
                  ptr_n = wrap_inc(g_idx);
               end
            end
         end
         LOCKED: begin
            // Owner withdrew, ended the burst, or hit the burst limit.
            if (!xfer || !sel_lock || (int'(cnt) + 1 == MAX_BURST)) begin
               state_n = IDLE;
               ptr_n   = wrap_inc(owner);
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers and read-return flag; async reset drops a pending rvalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         cnt    <= '0;
         rvalid <= '0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         owner  <= owner_n;
         cnt    <= cnt_n;
         rvalid <= gnt_c & ~we;
      end
   end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Directed bench for gbuff_arbiter with a behavioural single-port buffer
// (registered read, 1-cycle latency). MAX_BURST is set to 4.
module tb_gbuff_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req, we, lock;
   logic [23:0] addr;
   logic [95:0] wdata;
   logic [2:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        gb_wr_en;
   logic [7:0]  gb_index;
   logic [31:0] gb_data_in;
   logic [31:0] gb_data_out = '0;
   logic        dbg_locked;

   logic [31:0] mem [256];
   int          n_checks = 0;
   int          n_pass   = 0;

   logic [2:0]  g_exp [6];
   logic [31:0] d_exp [6];
   logic [2:0]  b_exp [6];
   logic        l_exp [6];

   gbuff_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_in(gb_data_in),
      .gb_data_out(gb_data_out), .dbg_locked(dbg_locked)
   );

   // clock
   always #5 clk = ~clk;

   // buffer model: read-before-write, registered output
   always @(posedge clk) begin
      if (gb_wr_en) mem[gb_index] <= gb_data_in;
      gb_data_out <= mem[gb_index];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_all();
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
   endtask

   task automatic drive(input int k, input logic w, input logic l,
                        input logic [7:0] a, input logic [31:0] d);
      req[k] = 1'b1;
      we[k]  = w;
      lock[k] = l;
      addr[k*8 +: 8]   = a;
      wdata[k*32 +: 32] = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      idle_all();

      // reset: grant suppressed even with all requesting
      req = 3'b111;
      #1;
      check("rst_gnt", {29'd0, gnt}, 32'd0);
      check("rst_rvalid", {29'd0, rvalid}, 32'd0);
      check("rst_wr_en", {31'd0, gb_wr_en}, 32'd0);
      check("rst_index", {24'd0, gb_index}, 32'd0);
      check("rst_data_in", gb_data_in, 32'd0);
      @(negedge clk); rst = 1'b0; idle_all();

      // single requester: write then read index 5
      @(negedge clk); idle_all(); drive(0, 1'b1, 1'b0, 8'd5, 32'hDEADBEEF); #1;
      check("t1_gnt_w", {29'd0, gnt}, 32'd1);
      check("t1_wr_en_w", {31'd0, gb_wr_en}, 32'd1);
      check("t1_index_w", {24'd0, gb_index}, 32'd5);
      check("t1_data_in", gb_data_in, 32'hDEADBEEF);
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd5, 32'h0); #1;
      check("t1_gnt_r", {29'd0, gnt}, 32'd1);
      check("t1_wr_en_r", {31'd0, gb_wr_en}, 32'd0);
      check("t1_no_rvalid_after_w", {29'd0, rvalid}, 32'd0);
      @(negedge clk); idle_all(); #1;
      check("t1_rvalid", {29'd0, rvalid}, 32'd1);
      check("t1_rdata", rdata, 32'hDEADBEEF);
      check("t1_wr_en_idle", {31'd0, gb_wr_en}, 32'd0);

      // preload indices 1..3, then reset and run three-way round robin
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); idle_all(); drive(0, 1'b1, 1'b0, 8'(i), 32'(i * 32'h11));
      end
      @(negedge clk); idle_all(); rst = 1'b1;
      g_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      d_exp = '{32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33};
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         idle_all();
         drive(0, 1'b0, 1'b0, 8'd1, 32'h0);
         drive(1, 1'b0, 1'b0, 8'd2, 32'h0);
         drive(2, 1'b0, 1'b0, 8'd3, 32'h0);
         #1;
         check($sformatf("rr_gnt%0d", i), {29'd0, gnt}, {29'd0, g_exp[i]});
         if (i > 0) begin
            check($sformatf("rr_rvalid%0d", i), {29'd0, rvalid}, {29'd0, g_exp[i-1]});
            check($sformatf("rr_rdata%0d", i), rdata, d_exp[i-1]);
         end
      end
      @(negedge clk); idle_all(); #1;
      check("rr_rvalid_last", {29'd0, rvalid}, 32'd4);
      check("rr_rdata_last", rdata, 32'h33);

      // locked burst by requester 1, forced release after 4 transfers
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd0, 32'h0); #1;
      check("lk_pre_gnt", {29'd0, gnt}, 32'd1);
      b_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
      l_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); idle_all();
         drive(0, 1'b0, 1'b0, 8'd1, 32'h0);
         drive(1, 1'b0, 1'b1, 8'd2, 32'h0);
         drive(2, 1'b0, 1'b0, 8'd3, 32'h0);
         #1;
         check($sformatf("lk_gnt%0d", i), {29'd0, gnt}, {29'd0, b_exp[i]});
         check($sformatf("lk_state%0d", i), {31'd0, dbg_locked}, {31'd0, l_exp[i]});
      end

      // requester 2 burst withdrawn after 2 transfers
      @(negedge clk); idle_all(); drive(2, 1'b0, 1'b1, 8'd3, 32'h0); #1;
      check("wd_gnt1", {29'd0, gnt}, 32'd4);
      @(negedge clk); idle_all(); drive(2, 1'b0, 1'b1, 8'd3, 32'h0);
      drive(0, 1'b0, 1'b0, 8'd1, 32'h0); #1;
      check("wd_gnt2", {29'd0, gnt}, 32'd4);
      check("wd_state2", {31'd0, dbg_locked}, 32'd1);
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd1, 32'h0); #1;
      check("wd_gnt3", {29'd0, gnt}, 32'd0);
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd1, 32'h0);
      drive(1, 1'b0, 1'b0, 8'd2, 32'h0); #1;
      check("wd_gnt4", {29'd0, gnt}, 32'd1);
      check("wd_state4", {31'd0, dbg_locked}, 32'd0);

      // reset during a locked burst with a read in flight
      @(negedge clk); idle_all(); drive(1, 1'b0, 1'b1, 8'd5, 32'h0); #1;
      check("mr_gnt1", {29'd0, gnt}, 32'd2);
      @(negedge clk); idle_all(); drive(1, 1'b0, 1'b1, 8'd5, 32'h0); #1;
      check("mr_gnt2", {29'd0, gnt}, 32'd2);
      check("mr_rvalid2", {29'd0, rvalid}, 32'd2);
      @(negedge clk); rst = 1'b1; #1;
      check("mr_rst_gnt", {29'd0, gnt}, 32'd0);
      check("mr_rst_rvalid", {29'd0, rvalid}, 32'd0);
      check("mr_rst_state", {31'd0, dbg_locked}, 32'd0);
      @(negedge clk); rst = 1'b0; idle_all();
      drive(0, 1'b0, 1'b0, 8'd0, 32'h0);
      drive(1, 1'b0, 1'b0, 8'd0, 32'h0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'h0); #1;
      check("mr_after_gnt", {29'd0, gnt}, 32'd1);
      @(negedge clk); idle_all(); #1;
      check("mr_after_rvalid", {29'd0, rvalid}, 32'd1);

      // idle for 10 cycles: buffer port parked at a read of index 0
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); idle_all(); #1;
         check($sformatf("id_wr_en%0d", i), {31'd0, gb_wr_en}, 32'd0);
         check($sformatf("id_index%0d", i), {24'd0, gb_index}, 32'd0);
         check($sformatf("id_rvalid%0d", i), {29'd0, rvalid}, 32'd0);
      end

      // readback of earlier writes
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd5, 32'h0); #1;
      check("rb_gnt", {29'd0, gnt}, 32'd1);
      @(negedge clk); idle_all(); drive(0, 1'b0, 1'b0, 8'd1, 32'h0); #1;
      check("rb_rvalid5", {29'd0, rvalid}, 32'd1);
      check("rb_rdata5", rdata, 32'hDEADBEEF);
      @(negedge clk); idle_all(); #1;
      check("rb_rvalid1", {29'd0, rvalid}, 32'd1);
      check("rb_rdata1", rdata, 32'h11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
